// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the PC, keeps one read outstanding, buffers {pc, inst} in a DEPTH-entry FIFO.
// Optional feature macro: IF_FETCH_BYPASS_EN (empty-FIFO response goes straight to the outputs).
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0060),
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] inst_addr,
    output logic            inst_read,
    input  logic            inst_resp,
    input  logic [XLEN-1:0] inst_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    input  logic            out_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {RUN, WAIT, DRAIN} state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pending_pc;
    logic [XLEN-1:0] fifo_pc   [DEPTH];
    logic [XLEN-1:0] fifo_inst [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    logic fifo_empty;
    logic fifo_full;
    logic accept;
    logic bypass;
    logic push;
    logic pop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign accept     = (state == WAIT) && inst_resp && !redirect;

`ifdef IF_FETCH_BYPASS_EN
    assign bypass = accept && fifo_empty && out_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !bypass;
    assign pop  = !fifo_empty && out_ready && !redirect;

    // A redirect in RUN suppresses the request so the old PC is never fetched.
    assign inst_addr = fetch_pc;
    assign inst_read = !reset && ((state == RUN) ? (!fifo_full && !redirect) : 1'b1);

    always_comb begin
        out_valid = 1'b0;
        out_inst  = '0;
        out_pc    = '0;
        if (!reset) begin
            if (bypass) begin
                out_valid = 1'b1;
                out_inst  = inst_rdata;
                out_pc    = fetch_pc;
            end else if (!fifo_empty) begin
                out_valid = 1'b1;
                out_inst  = fifo_inst[head];
                out_pc    = fifo_pc[head];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            fetch_pc   <= RESET_PC;
            pending_pc <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                    end else if (!fifo_full) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        if (inst_resp) begin
                            fetch_pc <= redirect_pc;
                            state    <= RUN;
                        end else begin
                            pending_pc <= redirect_pc;
                            state      <= DRAIN;
                        end
                    end else if (inst_resp) begin
                        fetch_pc <= fetch_pc + XLEN'(4);
                        state    <= RUN;
                    end
                end
                DRAIN: begin
                    // The stale response is swallowed; the most recent target wins.
                    if (redirect) begin
                        pending_pc <= redirect_pc;
                    end
                    if (inst_resp) begin
                        fetch_pc <= redirect ? redirect_pc : pending_pc;
                        state    <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_pc[tail]   <= fetch_pc;
            fifo_inst[tail] <= inst_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a per-cycle vector table plus hand-written multi-cycle sequences.
// Expected values follow IF_FETCH_BYPASS_EN when the bench is built with that macro.
module tb_if_fetch_queue;

`ifdef IF_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst_addr;
    logic        inst_read;
    logic        inst_resp;
    logic [31:0] inst_rdata;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    int n_resp = 0;
    bit pend   = 1'b0;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        resp;
        logic [31:0] rdata;
        logic        ready;
        logic        exp_read;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    if_fetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_addr   (inst_addr),
        .inst_read   (inst_read),
        .inst_resp   (inst_resp),
        .inst_rdata  (inst_rdata),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_ready   (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] byp_val(input logic [31:0] v);
        return BYP ? v : 32'd0;
    endfunction

    function automatic logic [31:0] reg_val(input logic [31:0] v);
        return BYP ? 32'd0 : v;
    endfunction

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        reset       = v.rst;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        inst_resp   = v.resp;
        inst_rdata  = v.rdata;
        out_ready   = v.ready;
        #1;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        checkVal($sformatf("row%0d inst_read", idx), 32'(inst_read), 32'(v.exp_read));
        checkVal($sformatf("row%0d inst_addr", idx), inst_addr, v.exp_addr);
        checkVal($sformatf("row%0d out_valid", idx), 32'(out_valid), 32'(v.exp_valid));
        checkVal($sformatf("row%0d out_pc", idx), out_pc, v.exp_pc);
        checkVal($sformatf("row%0d out_inst", idx), out_inst, v.exp_inst);
    endtask

    // Memory model: answers one cycle after it first sees a read.
    task automatic memDrive();
        inst_resp  = pend;
        inst_rdata = pend ? mem_data(inst_addr) : 32'd0;
        #1;
        if (inst_resp) n_resp++;
        pend = inst_read && !inst_resp;
    endtask

    task automatic doReset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        inst_resp   = 1'b0;
        inst_rdata  = 32'd0;
        out_ready   = 1'b1;
        pend        = 1'b0;
        n_resp      = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 1'b0, 32'h060, 1'b0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 1'b1, 32'h060, 1'b0, 32'h0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h1111_0001, 1'b1, 1'b1, 32'h060, BYP,  byp_val(32'h060), byp_val(32'h1111_0001)};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 1'b1, 32'h064, !BYP, reg_val(32'h060), reg_val(32'h1111_0001)};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h2222_0002, 1'b1, 1'b1, 32'h064, BYP,  byp_val(32'h064), byp_val(32'h2222_0002)};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 1'b1, 32'h068, !BYP, reg_val(32'h064), reg_val(32'h2222_0002)};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h3333_0003, 1'b1, 1'b1, 32'h068, BYP,  byp_val(32'h068), byp_val(32'h3333_0003)};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 1'b1, 32'h06C, !BYP, reg_val(32'h068), reg_val(32'h3333_0003)};
        vecs[8]  = '{1'b0, 1'b1, 32'h700, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1, 32'h06C, 1'b0, 32'h0, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 1'b1, 32'h700, 1'b0, 32'h0, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC0C0_0700, 1'b1, 1'b1, 32'h700, BYP,  byp_val(32'h700), byp_val(32'hC0C0_0700)};
        vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 1'b1, 32'h704, !BYP, reg_val(32'h700), reg_val(32'hC0C0_0700)};
        vecs[12] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 1'b0, 32'h704, 1'b0, 32'h0, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 1'b0, 32'h060, 1'b0, 32'h0, 32'h0};
        vecs[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hBAD1_BAD1, 1'b1, 1'b1, 32'h060, 1'b0, 32'h0, 32'h0};
        vecs[15] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 1'b1, 32'h060, 1'b0, 32'h0, 32'h0};
        vecs[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hD0D0_0060, 1'b1, 1'b1, 32'h060, BYP,  byp_val(32'h060), byp_val(32'hD0D0_0060)};
        vecs[17] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 1'b1, 32'h064, !BYP, reg_val(32'h060), reg_val(32'hD0D0_0060)};

        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        inst_resp   = 1'b0;
        inst_rdata  = 32'd0;
        out_ready   = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
            tick();
        end

        // Decode stalled for 20 cycles: the FIFO fills and fetch stops.
        doReset();
        out_ready = 1'b0;
        repeat (19) begin
            memDrive();
            tick();
        end
        memDrive();
        checkVal("stall inst_read", 32'(inst_read), 32'd0);
        checkVal("stall responses", 32'(n_resp), 32'd4);
        checkVal("stall head pc", out_pc, 32'h060);
        tick();
        for (int k = 0; k < 4; k++) begin
            out_ready = 1'b1;
            memDrive();
            checkVal($sformatf("drain%0d out_valid", k), 32'(out_valid), 32'd1);
            checkVal($sformatf("drain%0d out_pc", k), out_pc, 32'h060 + 32'(4 * k));
            checkVal($sformatf("drain%0d out_inst", k), out_inst, mem_data(32'h060 + 32'(4 * k)));
            checkVal($sformatf("drain%0d inst_read", k), 32'(inst_read), 32'(k != 0));
            tick();
        end

        // Redirect in RUN with three buffered entries.
        doReset();
        out_ready = 1'b0;
        repeat (6) begin
            memDrive();
            tick();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        memDrive();
        checkVal("runredir inst_read", 32'(inst_read), 32'd0);
        checkVal("runredir out_valid before", 32'(out_valid), 32'd1);
        checkVal("runredir head pc", out_pc, 32'h060);
        tick();
        redirect = 1'b0;
        memDrive();
        checkVal("runredir out_valid after", 32'(out_valid), 32'd0);
        checkVal("runredir inst_addr", inst_addr, 32'h200);
        checkVal("runredir inst_read after", 32'(inst_read), 32'd1);
        tick();

        // Redirect in WAIT; stale response arrives three cycles later.
        doReset();
        #1;
        checkVal("wait issue addr", inst_addr, 32'h060);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        #1;
        checkVal("wait redir read", 32'(inst_read), 32'd1);
        tick();
        redirect = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checkVal($sformatf("drain hold%0d read", k), 32'(inst_read), 32'd1);
            checkVal($sformatf("drain hold%0d addr", k), inst_addr, 32'h060);
            checkVal($sformatf("drain hold%0d valid", k), 32'(out_valid), 32'd0);
            tick();
        end
        inst_resp  = 1'b1;
        inst_rdata = 32'hDEAD_BEEF;
        #1;
        checkVal("stale resp valid", 32'(out_valid), 32'd0);
        checkVal("stale resp addr", inst_addr, 32'h060);
        tick();
        inst_resp  = 1'b0;
        inst_rdata = 32'd0;
        #1;
        checkVal("after drain read", 32'(inst_read), 32'd1);
        checkVal("after drain addr", inst_addr, 32'h400);
        checkVal("after drain valid", 32'(out_valid), 32'd0);
        tick();
        inst_resp  = 1'b1;
        inst_rdata = 32'h0400_1234;
        #1;
        checkVal("new resp valid", 32'(out_valid), 32'(BYP));
        checkVal("new resp pc", out_pc, byp_val(32'h400));
        tick();
        inst_resp  = 1'b0;
        inst_rdata = 32'd0;
        #1;
        checkVal("new entry valid", 32'(out_valid), 32'(!BYP));
        checkVal("new entry pc", out_pc, reg_val(32'h400));
        checkVal("new entry inst", out_inst, reg_val(32'h0400_1234));
        checkVal("new entry next addr", inst_addr, 32'h404);
        tick();

        // Two redirects while draining: the later target wins.
        doReset();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        #1;
        tick();
        redirect_pc = 32'h500;
        #1;
        checkVal("drain2 read", 32'(inst_read), 32'd1);
        checkVal("drain2 addr", inst_addr, 32'h060);
        tick();
        redirect   = 1'b0;
        inst_resp  = 1'b1;
        inst_rdata = 32'hBAD2_BAD2;
        #1;
        checkVal("drain2 stale valid", 32'(out_valid), 32'd0);
        tick();
        inst_resp = 1'b0;
        #1;
        checkVal("drain2 resume read", 32'(inst_read), 32'd1);
        checkVal("drain2 resume addr", inst_addr, 32'h500);
        checkVal("drain2 resume valid", 32'(out_valid), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
